img_ram_scheduler: RTL and testbench

IMG_RAM_SCHEDULER -- requirements
Module: img_ram_scheduler

---
 rtl/img_ram_scheduler_if.sv | 31 +++
 rtl/img_ram_scheduler.sv | 128 ++++++++++++
 tb/tb_img_ram_scheduler.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/img_ram_scheduler_if.sv
// Shared-RAM request/grant bundle between the two image stages and the scheduler.
// The scheduler uses the slave view; the stages and the RAM model use the master view.
interface img_ram_scheduler_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int BYTE_WIDTH = 8
);
  logic                  g_ren;
  logic                  g_wen;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [BYTE_WIDTH-1:0] g_wdata;
  logic                  b_ren;
  logic                  b_wen;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [BYTE_WIDTH-1:0] b_wdata;
  logic                  RAM_ren;
  logic                  RAM_wen;
  logic [ADDR_WIDTH-1:0] RAM_addr;
  logic [BYTE_WIDTH-1:0] RAM_in;

  modport master (
    output g_ren, g_wen, g_addr, g_wdata,
    output b_ren, b_wen, b_addr, b_wdata,
    input  RAM_ren, RAM_wen, RAM_addr, RAM_in
  );

  modport slave (
    input  g_ren, g_wen, g_addr, g_wdata,
    input  b_ren, b_wen, b_addr, b_wdata,
    output RAM_ren, RAM_wen, RAM_addr, RAM_in
  );
endinterface

// File: rtl/img_ram_scheduler.sv
// Sequences the grayscale then binarization stages onto one shared RAM port,
// with a per-stage watchdog and a count of granted RAM writes.
module img_ram_scheduler #(
  parameter int ADDR_WIDTH = 20,
  parameter int BYTE_WIDTH = 8,
  parameter int TIMEOUT    = 2**21
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  gray_done,
  input  logic                  bin_done,
  img_ram_scheduler_if.slave    bus,
  output logic                  gray_go,
  output logic                  bin_go,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] wr_count
);
  localparam int WD_W = ADDR_WIDTH + 2;
  localparam logic [WD_W-1:0] WD_TERM = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, GRAY_RUN, SWITCH, BIN_RUN, FINISH, ERROR
  } state_t;

  state_t                state_q;
  logic [WD_W-1:0]       wd_q;
  logic [ADDR_WIDTH-1:0] wr_count_q;

  logic                  ram_ren;
  logic                  ram_wen;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [BYTE_WIDTH-1:0] ram_in;

  // Grant is decoded from the state register so reset drops it without a clock edge.
  always_comb begin
    ram_ren  = 1'b0;
    ram_wen  = 1'b0;
    ram_addr = '0;
    ram_in   = '0;
    case (state_q)
      GRAY_RUN: begin
        ram_wen  = bus.g_wen;
        ram_ren  = bus.g_ren & ~bus.g_wen;
        ram_addr = bus.g_addr;
        ram_in   = bus.g_wdata;
      end
      BIN_RUN: begin
        ram_wen  = bus.b_wen;
        ram_ren  = bus.b_ren & ~bus.b_wen;
        ram_addr = bus.b_addr;
        ram_in   = bus.b_wdata;
      end
      default: ;
    endcase
  end

  assign bus.RAM_ren  = ram_ren;
  assign bus.RAM_wen  = ram_wen;
  assign bus.RAM_addr = ram_addr;
  assign bus.RAM_in   = ram_in;

  assign gray_go  = (state_q == GRAY_RUN);
  assign bin_go   = (state_q == BIN_RUN);
  assign busy     = (state_q == GRAY_RUN) || (state_q == SWITCH) || (state_q == BIN_RUN);
  assign done     = (state_q == FINISH);
  assign err      = (state_q == ERROR);
  assign wr_count = wr_count_q;

  // Every branch that changes state also clears the watchdog; a stage done beats timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wd_q       <= '0;
      wr_count_q <= '0;
    end else begin
      if (ram_wen) wr_count_q <= wr_count_q + 1'b1;
      if (abort) begin
        state_q <= IDLE;
        wd_q    <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              state_q    <= GRAY_RUN;
              wd_q       <= '0;
              wr_count_q <= '0;
            end
          end
          GRAY_RUN: begin
            if (gray_done) begin
              state_q <= SWITCH;
              wd_q    <= '0;
            end else if (wd_q == WD_TERM) begin
              state_q <= ERROR;
              wd_q    <= '0;
            end else begin
              wd_q <= wd_q + 1'b1;
            end
          end
          SWITCH: begin
            state_q <= BIN_RUN;
            wd_q    <= '0;
          end
          BIN_RUN: begin
            if (bin_done) begin
              state_q <= FINISH;
              wd_q    <= '0;
            end else if (wd_q == WD_TERM) begin
              state_q <= ERROR;
              wd_q    <= '0;
            end else begin
              wd_q <= wd_q + 1'b1;
            end
          end
          FINISH: begin
            state_q <= IDLE;
            wd_q    <= '0;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_img_ram_scheduler.sv
// Directed bench for img_ram_scheduler: grant-mux vector table plus hand-built
// sequences for normal run, timeout, abort and mid-run reset.
module tb_img_ram_scheduler;
  localparam int AW = 8;
  localparam int BW = 8;

  logic clk = 1'b0;
  logic rst, start, abort, gray_done, bin_done;
  logic gray_go, bin_go, busy, done, err;
  logic [AW-1:0] wr_count;

  int checks = 0;
  int errors = 0;

  img_ram_scheduler_if #(.ADDR_WIDTH(AW), .BYTE_WIDTH(BW)) bus ();

  img_ram_scheduler #(.ADDR_WIDTH(AW), .BYTE_WIDTH(BW), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .gray_done(gray_done), .bin_done(bin_done), .bus(bus),
    .gray_go(gray_go), .bin_go(bin_go), .busy(busy), .done(done),
    .err(err), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         ph;
    logic       g_ren, g_wen;
    logic [7:0] g_addr, g_wdata;
    logic       b_ren, b_wen;
    logic [7:0] b_addr, b_wdata;
    logic       e_ren, e_wen;
    logic [7:0] e_addr, e_in;
  } vec_t;

  vec_t vt[8];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clr_req();
    bus.g_ren = 0; bus.g_wen = 0; bus.g_addr = 0; bus.g_wdata = 0;
    bus.b_ren = 0; bus.b_wen = 0; bus.b_addr = 0; bus.b_wdata = 0;
  endtask

  task automatic set_req(vec_t v);
    bus.g_ren = v.g_ren; bus.g_wen = v.g_wen; bus.g_addr = v.g_addr; bus.g_wdata = v.g_wdata;
    bus.b_ren = v.b_ren; bus.b_wen = v.b_wen; bus.b_addr = v.b_addr; bus.b_wdata = v.b_wdata;
  endtask

  task automatic pulse_start();
    start = 1; @(negedge clk); start = 0;
  endtask

  initial begin
    int model_wr;
    int gcnt;
    int bcnt;
    int dcnt;
    int prev_ph;

    rst = 1; start = 0; abort = 0; gray_done = 0; bin_done = 0;
    clr_req();
    #1;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_err", 32'(err), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_wrcount", 32'(wr_count), 0);
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    #1 chk("idle_no_start", 32'(busy), 0);

    // abort wins over start in IDLE
    start = 1; abort = 1; @(negedge clk); start = 0; abort = 0;
    #1 chk("abort_over_start", 32'(busy), 0);

    // grant-mux table
    vt[0] = '{0, 1, 1, 8'h12, 8'h34, 1, 1, 8'h56, 8'h78, 0, 0, 8'h00, 8'h00};
    vt[1] = '{1, 1, 0, 8'h11, 8'hAA, 0, 1, 8'h36, 8'h01, 1, 0, 8'h11, 8'hAA};
    vt[2] = '{1, 0, 1, 8'h22, 8'h5B, 1, 0, 8'h36, 8'h02, 0, 1, 8'h22, 8'h5B};
    vt[3] = '{1, 1, 1, 8'h33, 8'hC3, 0, 0, 8'h00, 8'h00, 0, 1, 8'h33, 8'hC3};
    vt[4] = '{1, 0, 0, 8'h00, 8'h00, 0, 1, 8'h36, 8'h03, 0, 0, 8'h00, 8'h00};
    vt[5] = '{2, 1, 0, 8'h77, 8'h10, 1, 0, 8'h44, 8'h99, 1, 0, 8'h44, 8'h99};
    vt[6] = '{2, 0, 0, 8'h00, 8'h00, 1, 1, 8'h55, 8'h66, 0, 1, 8'h55, 8'h66};
    vt[7] = '{2, 0, 1, 8'h77, 8'h20, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00};

    model_wr = 0;
    prev_ph = 0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (vt[i].ph != prev_ph) begin
        clr_req();
        if (vt[i].ph == 1) begin
          pulse_start();
        end else begin
          gray_done = 1; @(negedge clk); gray_done = 0;
          bus.g_wen = 1;
          #1;
          chk("switch_busy", 32'(busy), 1);
          chk("switch_no_grant", 32'(bus.RAM_wen), 0);
          chk("switch_no_go", 32'({gray_go, bin_go}), 0);
          @(negedge clk);
          clr_req();
        end
        prev_ph = vt[i].ph;
      end
      set_req(vt[i]);
      #1;
      $display("vec %0d ph=%0d ren=%0b wen=%0b addr=%02h in=%02h", i, vt[i].ph,
               bus.RAM_ren, bus.RAM_wen, bus.RAM_addr, bus.RAM_in);
      chk($sformatf("vec%0d_ren", i), 32'(bus.RAM_ren), 32'(vt[i].e_ren));
      chk($sformatf("vec%0d_wen", i), 32'(bus.RAM_wen), 32'(vt[i].e_wen));
      chk($sformatf("vec%0d_addr", i), 32'(bus.RAM_addr), 32'(vt[i].e_addr));
      chk($sformatf("vec%0d_in", i), 32'(bus.RAM_in), 32'(vt[i].e_in));
      chk($sformatf("vec%0d_go", i), 32'({gray_go, bin_go}),
          (vt[i].ph == 1) ? 32'd2 : (vt[i].ph == 2) ? 32'd1 : 32'd0);
      if (vt[i].e_wen) model_wr++;
      @(negedge clk);
    end
    clr_req();
    #1 chk("table_wrcount", 32'(wr_count), 32'(model_wr));
    // start ignored in BIN_RUN
    pulse_start();
    #1 chk("bin_start_ignored", 32'({gray_go, bin_go}), 1);
    bin_done = 1; @(negedge clk); bin_done = 0;
    #1 chk("table_finish_done", 32'(done), 1);
    @(negedge clk);
    #1 chk("table_idle_done", 32'(done), 0);
    chk("table_wr_hold", 32'(wr_count), 32'(model_wr));
    $display("table section complete wr_count=%0d", wr_count);

    // normal run: 10 gray cycles (6 writes), switch, 8 bin cycles (4 writes)
    gcnt = 0; bcnt = 0; dcnt = 0;
    pulse_start();
    for (int c = 0; c < 10; c++) begin
      bus.g_wen = (c < 6); bus.g_addr = 8'(c); gray_done = (c == 9);
      #1 gcnt += int'(gray_go);
      @(negedge clk);
    end
    clr_req(); gray_done = 0;
    #1;
    chk("run_gray_cycles", 32'(gcnt), 10);
    chk("run_switch_idle", 32'({gray_go, bin_go, busy}), 1);
    @(negedge clk);
    for (int c = 0; c < 8; c++) begin
      bus.b_wen = (c < 4); bus.b_addr = 8'(c); bin_done = (c == 7);
      #1 bcnt += int'(bin_go);
      @(negedge clk);
    end
    clr_req(); bin_done = 0;
    for (int c = 0; c < 3; c++) begin
      #1 dcnt += int'(done);
      @(negedge clk);
    end
    chk("run_bin_cycles", 32'(bcnt), 8);
    chk("run_done_pulses", 32'(dcnt), 1);
    chk("run_wrcount", 32'(wr_count), 10);
    $display("normal run gray=%0d bin=%0d done=%0d wr=%0d", gcnt, bcnt, dcnt, wr_count);

    // timeout: ERROR 16 cycles after GRAY_RUN entry
    gcnt = 0;
    pulse_start();
    for (int c = 0; c < 16; c++) begin
      #1 gcnt += int'(gray_go && !err);
      @(negedge clk);
    end
    #1;
    chk("timeout_gray_cycles", 32'(gcnt), 16);
    chk("timeout_err", 32'(err), 1);
    chk("timeout_busy", 32'(busy), 0);
    pulse_start();
    repeat (2) @(negedge clk);
    #1 chk("timeout_err_held", 32'(err), 1);
    abort = 1; @(negedge clk); abort = 0;
    #1 chk("abort_clears_err", 32'({err, busy}), 0);
    $display("timeout section complete");

    // done on the terminal-count cycle beats timeout
    pulse_start();
    for (int c = 0; c < 16; c++) begin
      gray_done = (c == 15);
      @(negedge clk);
    end
    gray_done = 0;
    #1 chk("done_beats_timeout", 32'({err, busy, gray_go}), 32'b010);
    @(negedge clk);
    #1 chk("enter_bin", 32'(bin_go), 1);

    // abort together with bin_done: straight to IDLE, no done
    bus.b_wen = 1; bin_done = 1; abort = 1;
    @(negedge clk);
    bin_done = 0; abort = 0;
    #1;
    chk("abort_bin_busy", 32'(busy), 0);
    chk("abort_bin_grant", 32'(bus.RAM_wen), 0);
    chk("abort_bin_done", 32'(done), 0);
    @(negedge clk);
    #1 chk("abort_bin_no_late_done", 32'(done), 0);
    clr_req();

    // reset mid-run removes the grant without a clock edge
    pulse_start();
    bus.g_wen = 1;
    repeat (3) @(negedge clk);
    bus.g_wen = 0; gray_done = 1; @(negedge clk); gray_done = 0;
    @(negedge clk);
    bus.b_wen = 1;
    #1 chk("pre_reset_grant", 32'(bus.RAM_wen), 1);
    #2 rst = 1;
    #1;
    chk("reset_async_grant", 32'(bus.RAM_wen), 0);
    chk("reset_async_busy", 32'(busy), 0);
    chk("reset_async_wr", 32'(wr_count), 0);
    @(negedge clk);
    rst = 0; clr_req();
    @(negedge clk);
    #1 chk("post_reset_idle", 32'(busy), 0);
    pulse_start();
    bus.g_wen = 1;
    repeat (2) @(negedge clk);
    bus.g_wen = 0;
    #1 chk("fresh_run_wrcount", 32'(wr_count), 2);
    $display("reset section complete wr_count=%0d", wr_count);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
